btn_debounce_sel: RTL and testbench

BTN_DEBOUNCE_SEL -- requirements
Module: btn_debounce_sel

---
 rtl/btn_debounce_sel.sv | 150 +++++++++++++++
 tb/tb_btn_debounce_sel.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_sel.sv
// Pushbutton debouncer driving a display select toggle.
// Optional free-running select toggle enabled by AUTO_SCAN_EN.
module btn_debounce_sel #(
  parameter int DEBOUNCE_CYCLES  = 270000,
  parameter bit BTN_ACTIVE_LOW   = 1'b1,
  parameter int AUTO_SCAN_CYCLES = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic sel,
  output logic press,
  output logic btn_stable
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          btn_n;
  logic          sync1, btn_s;
  logic          cnt_last;
  logic          press_evt;
  logic          sel_flip;

  assign btn_n    = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;
  assign cnt_last = (cnt == CNT_LAST);

  // two-flop synchroniser on the normalised pin
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_n;
      btn_s <= sync1;
    end
  end

  // debounce state and stable-sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next-state logic; press_evt marks the accepted press edge
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = DEB_PRESS;
          cnt_n   = '0;
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_last) begin
          state_n   = PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_n = DEB_RELEASE;
          cnt_n   = '0;
        end
      end
      DEB_RELEASE: begin
        if (btn_s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt_last) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign btn_stable = (state == PRESSED) ||
                      (state == DEB_RELEASE);

`ifdef AUTO_SCAN_EN
  localparam int SW =
    (AUTO_SCAN_CYCLES > 1) ? $clog2(AUTO_SCAN_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST =
    SW'(AUTO_SCAN_CYCLES - 1);

  logic [SW-1:0] scan_cnt;
  logic          scan_exp;

  assign scan_exp = (scan_cnt == SCAN_LAST);

  // scan period timer, restarted by expiry or a press
  always_ff @(posedge clk) begin
    if (rst)
      scan_cnt <= '0;
    else if (press_evt || scan_exp)
      scan_cnt <= '0;
    else
      scan_cnt <= scan_cnt + SW'(1);
  end

  assign sel_flip = press_evt | scan_exp;
`else
  localparam bit SCAN_OK = (AUTO_SCAN_CYCLES > 0);

  assign sel_flip = press_evt & SCAN_OK;
`endif

  // registered press pulse and select toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      press <= 1'b0;
      sel   <= 1'b0;
    end else begin
      press <= press_evt;
      if (sel_flip)
        sel <= ~sel;
    end
  end

endmodule

// File: tb/tb_btn_debounce_sel.sv
// Bench for btn_debounce_sel: press scoreboard plus level checks.
// Auto-scan scenario runs when AUTO_SCAN_EN is defined.
module tb_btn_debounce_sel;

  localparam int DEB  = 4;
  localparam int SCAN = 20;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic btn_raw = 1'b1;
  logic sel;
  logic press;
  logic btn_stable;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int   at;
    logic sel;
  } exp_t;

  exp_t sb[$];
  logic press_q = 1'b0;

  btn_debounce_sel #(
    .DEBOUNCE_CYCLES (DEB),
    .BTN_ACTIVE_LOW  (1'b1),
    .AUTO_SCAN_CYCLES(SCAN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .sel       (sel),
    .press     (press),
    .btn_stable(btn_stable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_press(input int at, input logic s);
    exp_t e;
    e.at  = at;
    e.sel = s;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (press) begin
      if (sb.size() == 0) begin
        chk("press_unexp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("press_cyc", cyc, e.at);
        chk("press_sel", {31'd0, sel}, {31'd0, e.sel});
      end
      chk("press_1cyc", {31'd0, press_q}, 32'd0);
    end
    press_q = press;
  end

`ifdef AUTO_SCAN_EN
  task automatic run_scan();
    int r;
    rst = 1'b1;
    btn_raw = 1'b1;
    tick(3);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    rst = 1'b0;
    r = cyc;
    tick(SCAN - 1);
    chk("sc_pre1", {31'd0, sel}, 32'd0);
    tick(1);
    chk("sc_tog1", {31'd0, sel}, 32'd1);
    tick(SCAN - 1);
    chk("sc_pre2", {31'd0, sel}, 32'd1);
    tick(1);
    chk("sc_tog2", {31'd0, sel}, 32'd0);
    tick(3 * SCAN - (DEB + 3) - 2 * SCAN);
    btn_raw = 1'b0;
    expect_press(r + 3 * SCAN, 1'b1);
    tick(DEB + 3);
    chk("sc_single", {31'd0, sel}, 32'd1);
    chk("sc_at", cyc, r + 3 * SCAN);
    tick(SCAN - 1);
    chk("sc_restart", {31'd0, sel}, 32'd1);
    tick(1);
    chk("sc_tog4", {31'd0, sel}, 32'd0);
    tick(2);
    chk("sb_empty", sb.size(), 32'd0);
  endtask
`else
  task automatic run_main();
    int n0;
    rst = 1'b1;
    btn_raw = 1'b1;
    tick(3);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    chk("rst_press", {31'd0, press}, 32'd0);
    chk("rst_stable", {31'd0, btn_stable}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("idle_sel", {31'd0, sel}, 32'd0);
      chk("idle_press", {31'd0, press}, 32'd0);
      chk("idle_stable", {31'd0, btn_stable}, 32'd0);
    end

    tick(1);
    btn_raw = 1'b0;
    n0 = cyc;
    expect_press(n0 + DEB + 3, 1'b1);
    tick(DEB + 2);
    chk("prs_pre", {31'd0, btn_stable}, 32'd0);
    tick(1);
    chk("prs_stable", {31'd0, btn_stable}, 32'd1);
    chk("prs_sel", {31'd0, sel}, 32'd1);
    tick(100);
    chk("hold_stable", {31'd0, btn_stable}, 32'd1);
    chk("hold_sel", {31'd0, sel}, 32'd1);

    btn_raw = 1'b1;
    tick(DEB + 2);
    chk("rel_pre", {31'd0, btn_stable}, 32'd1);
    tick(1);
    chk("rel_stable", {31'd0, btn_stable}, 32'd0);
    chk("rel_sel", {31'd0, sel}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      btn_raw = (i % 2 == 1);
      tick(2);
      chk("bnc_stable", {31'd0, btn_stable}, 32'd0);
    end
    btn_raw = 1'b1;
    tick(20);
    chk("bnc_sel", {31'd0, sel}, 32'd1);
    chk("bnc_stable_end", {31'd0, btn_stable}, 32'd0);

    btn_raw = 1'b0;
    n0 = cyc;
    expect_press(n0 + DEB + 3, 1'b0);
    tick(DEB + 3);
    chk("gl_stable", {31'd0, btn_stable}, 32'd1);
    chk("gl_sel", {31'd0, sel}, 32'd0);
    tick(5);
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("gl_hold", {31'd0, btn_stable}, 32'd1);
    end
    btn_raw = 1'b1;
    tick(DEB + 3);
    chk("gl_rel", {31'd0, btn_stable}, 32'd0);
    chk("gl_sel_end", {31'd0, sel}, 32'd0);

    tick(2);
    btn_raw = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("rsm_stable", {31'd0, btn_stable}, 32'd0);
    chk("rsm_sel", {31'd0, sel}, 32'd0);
    chk("rsm_press", {31'd0, press}, 32'd0);
    rst = 1'b0;
    expect_press(cyc + 7, 1'b1);
    tick(6);
    chk("rsm_pre", {31'd0, btn_stable}, 32'd0);
    tick(1);
    chk("rsm_on", {31'd0, btn_stable}, 32'd1);
    chk("rsm_sel_on", {31'd0, sel}, 32'd1);

    btn_raw = 1'b1;
    tick(DEB + 5);
    chk("end_stable", {31'd0, btn_stable}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef AUTO_SCAN_EN
    run_scan();
`else
    run_main();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
